// File: rtl/uart_peripheral_if.sv
// CPU MEM-stage bus seen by the UART: word address, store data, strobes
// and the combinational read-data return path.
interface uart_peripheral_if;
    logic [31:0] Addr;
    logic [31:0] DataIn;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] DataOut;

    modport master (output Addr, DataIn, MemRead, MemWrite, input DataOut);
    modport slave  (input Addr, DataIn, MemRead, MemWrite, output DataOut);
endinterface

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON word registers, independent TX and RX
// bit engines, sticky status flags and a level interrupt request.
module uart_peripheral #(
    parameter logic [31:0] BASE_ADDR    = 32'h40000018,
    parameter int          CLKS_PER_BIT = 10417
) (
    input  logic              clk,
    input  logic              reset,
    uart_peripheral_if.slave  bus,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic              irq
);

    localparam logic [31:0] TXD_ADDR  = BASE_ADDR;
    localparam logic [31:0] RXD_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] CON_ADDR  = BASE_ADDR + 32'd8;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      tx_state, rx_state;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_byte, tx_shift, rx_shift, rx_data;
    logic        tx_busy, tx_done, rx_valid, overrun, frame_err;
    logic        tx_int_en, rx_int_en;
    logic        rx_meta, rx_s, rx_prev;

    logic txd_write, con_write, rxd_read, con_read, tx_end, tx_accept;
    logic unused_data;

    assign txd_write   = bus.MemWrite && (bus.Addr == TXD_ADDR);
    assign con_write   = bus.MemWrite && (bus.Addr == CON_ADDR);
    assign rxd_read    = bus.MemRead  && (bus.Addr == RXD_ADDR);
    assign con_read    = bus.MemRead  && (bus.Addr == CON_ADDR);
    assign unused_data = ^bus.DataIn[31:8];

    // A write landing on the final stop-bit edge is accepted back to back.
    assign tx_end    = (tx_state == STOP) && (tx_cnt == BIT_LAST);
    assign tx_accept = txd_write && (!tx_busy || tx_end);

    assign irq = (tx_done & tx_int_en) | (rx_valid & rx_int_en);

    always_comb begin
        bus.DataOut = '0;
        if (bus.MemRead) begin
            case (bus.Addr)
                TXD_ADDR: bus.DataOut = {24'b0, tx_byte};
                RXD_ADDR: bus.DataOut = {24'b0, rx_data};
                CON_ADDR: bus.DataOut = {25'b0, frame_err, overrun, tx_busy,
                                         rx_valid, tx_done, rx_int_en, tx_int_en};
                default:  bus.DataOut = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_int_en <= 1'b0;
            rx_int_en <= 1'b0;
        end else if (con_write) begin
            {rx_int_en, tx_int_en} <= bus.DataIn[1:0];
        end
    end

    // Clears from a CON read come first so a completion on the same edge wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_shift <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            if (con_read) tx_done <= 1'b0;
            if (tx_accept) begin
                tx_byte  <= bus.DataIn[7:0];
                tx_shift <= bus.DataIn[7:0];
                tx_state <= START;
                tx_cnt   <= '0;
                tx_busy  <= 1'b1;
                uart_tx  <= 1'b0;
                if (tx_end) tx_done <= 1'b1;
            end else begin
                case (tx_state)
                    START: if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= DATA;
                    end else tx_cnt <= tx_cnt + 16'd1;
                    DATA: if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else tx_cnt <= tx_cnt + 16'd1;
                    STOP: if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                        tx_state <= IDLE;
                    end else tx_cnt <= tx_cnt + 16'd1;
                    default: tx_cnt <= '0;
                endcase
            end
        end
    end

    // Start is detected on a falling rx_s so a stuck-low line after a framing
    // error cannot retrigger; sampling is mid-bit after the half-bit wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (rxd_read) rx_valid <= 1'b0;
            if (con_read) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            case (rx_state)
                IDLE: if (rx_prev && !rx_s) begin
                    rx_cnt   <= '0;
                    rx_state <= START;
                end
                START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s ? IDLE : DATA;
                end else rx_cnt <= rx_cnt + 16'd1;
                DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state <= STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt + 16'd1;
                STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_state <= IDLE;
                    if (rx_s) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        if (rx_valid && !rxd_read) overrun <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else rx_cnt <= rx_cnt + 16'd1;
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Randomized self-checking bench for uart_peripheral against a register-level
// model of the flags and a bit-timed view of the serial frames.
module tb_uart_peripheral;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h40000018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx, irq;

    uart_peripheral_if bus();

    uart_peripheral #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] mTxByte, mRxData;
    bit mTxEn, mRxEn, mTxBusy, mTxDone, mRxValid, mOverrun, mFrameErr;

    task automatic modelReset();
        mTxByte = 8'h00; mRxData = 8'h00;
        mTxEn = 0; mRxEn = 0; mTxBusy = 0; mTxDone = 0;
        mRxValid = 0; mOverrun = 0; mFrameErr = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        case (a)
            TXD:     return {24'b0, mTxByte};
            RXD:     return {24'b0, mRxData};
            CON:     return {25'b0, mFrameErr, mOverrun, mTxBusy, mRxValid,
                             mTxDone, mRxEn, mTxEn};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] modelIrq();
        return {31'b0, (mTxDone && mTxEn) || (mRxValid && mRxEn)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Bus tasks start and end just after a negedge; the access edge is the posedge between.
    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        bus.Addr = a; bus.DataIn = d; bus.MemWrite = 1'b1;
        @(negedge clk);
        bus.MemWrite = 1'b0; bus.Addr = '0;
        if (a == CON) {mRxEn, mTxEn} = d[1:0];
        if (a == TXD && !mTxBusy) begin
            mTxByte = d[7:0];
            mTxBusy = 1;
        end
    endtask

    task automatic readCheck(input logic [31:0] a, input string tag);
        logic [31:0] d;
        bus.Addr = a; bus.MemRead = 1'b1;
        #1 d = bus.DataOut;
        checkOutput(tag, d, modelRead(a));
        @(negedge clk);
        bus.MemRead = 1'b0; bus.Addr = '0;
        if (a == RXD) mRxValid = 0;
        if (a == CON) begin mTxDone = 0; mOverrun = 0; mFrameErr = 0; end
    endtask

    // Called 2.5 cycles after the accepting edge; samples the middle of each bit.
    task automatic checkTxFrame(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("tx_bit%0d", i), {31'b0, uart_tx}, {31'b0, bits[i]});
            if (i < 9) repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stopBit);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        if (stopBit) begin
            if (mRxValid) mOverrun = 1;
            mRxData = b;
            mRxValid = 1;
        end else begin
            mFrameErr = 1;
        end
    endtask

    initial begin
        #200000;
        failCount++;
        $display("[TB] FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        logic [7:0] b1, b2, b3, rb, tb;
        bit stopBit;
        bus.Addr = '0; bus.DataIn = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        modelReset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_tx", {31'b0, uart_tx}, 32'h1);
        checkOutput("rst_irq", {31'b0, irq}, modelIrq());
        readCheck(TXD, "rst_txd");
        readCheck(RXD, "rst_rxd");
        readCheck(CON, "rst_con");

        $display("[TB] reset mid frame");
        busWrite(TXD, 32'hF0);
        repeat (6) @(negedge clk);
        checkOutput("tx_pre_rst", {31'b0, uart_tx}, 32'h0);
        reset = 1'b0;
        modelReset();
        #1 checkOutput("tx_in_rst", {31'b0, uart_tx}, 32'h1);
        checkOutput("irq_in_rst", {31'b0, irq}, modelIrq());
        @(negedge clk);
        readCheck(CON, "con_in_rst");
        reset = 1'b1;
        @(negedge clk);
        busWrite(TXD, 32'h55);
        repeat (2) @(negedge clk);
        checkTxFrame(8'h55);
        repeat (3) @(negedge clk);
        mTxBusy = 0; mTxDone = 1;
        readCheck(CON, "con_after_55");

        $display("[TB] tx frame with interrupt");
        busWrite(CON, 32'h1);
        busWrite(TXD, 32'hA5);
        repeat (2) @(negedge clk);
        checkTxFrame(8'hA5);
        @(negedge clk);
        readCheck(CON, "con_last_busy");
        mTxBusy = 0; mTxDone = 1;
        checkOutput("irq_tx_done", {31'b0, irq}, modelIrq());
        readCheck(CON, "con_tx_done");
        checkOutput("irq_tx_clr", {31'b0, irq}, modelIrq());

        $display("[TB] write while busy and back-to-back accept");
        b1 = 8'($urandom);
        b2 = ~b1;
        busWrite(TXD, {24'b0, b1});
        busWrite(TXD, {24'b0, b2});
        readCheck(TXD, "txd_ignored");
        checkTxFrame(b1);
        @(negedge clk);
        mTxBusy = 0; mTxDone = 1;
        b3 = 8'($urandom);
        busWrite(TXD, {24'b0, b3});
        repeat (2) @(negedge clk);
        checkTxFrame(b3);
        repeat (3) @(negedge clk);
        mTxBusy = 0; mTxDone = 1;
        for (int i = 0; i < 3; i++) begin
            repeat (CPB) @(negedge clk);
            checkOutput("tx_idle", {31'b0, uart_tx}, 32'h1);
        end
        checkOutput("irq_b3", {31'b0, irq}, modelIrq());
        readCheck(CON, "con_b3");
        readCheck(TXD, "txd_b3");

        $display("[TB] rx frame");
        busWrite(CON, 32'h2);
        applyStimulus(8'h96, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("irq_rx", {31'b0, irq}, modelIrq());
        readCheck(RXD, "rxd_96");
        checkOutput("irq_rx_clr", {31'b0, irq}, modelIrq());
        readCheck(CON, "con_rx_clr");

        $display("[TB] overrun and framing error");
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        readCheck(CON, "con_overrun");
        applyStimulus(8'($urandom), 1'b0);
        repeat (2) @(negedge clk);
        readCheck(CON, "con_frame_err");
        readCheck(RXD, "rxd_kept");

        $display("[TB] glitch and decode");
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        readCheck(CON, "con_glitch");
        rb = 8'($urandom);
        applyStimulus(rb, 1'b1);
        repeat (2) @(negedge clk);
        readCheck(RXD, "rxd_after_glitch");
        readCheck(BASE + 32'hC, "addr_unmapped");
        readCheck(BASE ^ 32'h8000_0000, "addr_high_bit");
        bus.Addr = TXD; bus.MemRead = 1'b0;
        #1 checkOutput("no_memread", bus.DataOut, 32'h0);
        @(negedge clk);
        bus.Addr = '0;

        $display("[TB] randomized concurrent tx/rx");
        for (int n = 0; n < 6; n++) begin
            busWrite(CON, 32'($urandom_range(0, 3)));
            rb = 8'($urandom);
            tb = 8'($urandom);
            stopBit = ($urandom_range(0, 3) != 0);
            fork
                applyStimulus(rb, stopBit);
                begin
                    busWrite(TXD, {24'b0, tb});
                    repeat (2) @(negedge clk);
                    checkTxFrame(tb);
                end
            join
            repeat (3) @(negedge clk);
            mTxBusy = 0; mTxDone = 1;
            checkOutput("irq_rand", {31'b0, irq}, modelIrq());
            if ($urandom_range(0, 1) == 1) readCheck(RXD, "rxd_rand");
            readCheck(CON, "con_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
